// File: rtl/stream_demux_1to2_32bit.sv
// One-to-two stream demultiplexer: each input word is routed by sel into a
// one-entry holding register per channel, with a per-channel accept counter.
module stream_demux_1to2_32bit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [31:0]      out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [31:0]      out1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    logic             out_ready_arr [2];
    logic             valid_arr     [2];
    logic             space_arr     [2];
    logic [31:0]      data_arr      [2];
    logic [CNT_W-1:0] cnt_arr       [2];

    assign out_ready_arr[0] = out0_ready;
    assign out_ready_arr[1] = out1_ready;

    // A channel can take a word if it is empty or is being drained this edge.
    assign in_ready = space_arr[sel];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            chan_state_t      state_reg, state_next;
            logic [31:0]      data_reg, data_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic             load;
            logic             drain;

            assign space_arr[gi] = (state_reg == EMPTY) || out_ready_arr[gi];
            assign load          = in_valid && space_arr[gi] && (sel == 1'(gi));
            assign drain         = (state_reg == FULL) && out_ready_arr[gi];

            always_comb begin
                state_next = state_reg;
                data_next  = data_reg;
                cnt_next   = cnt_reg;
                case (state_reg)
                    EMPTY: begin
                        if (load) begin
                            state_next = FULL;
                            data_next  = in_data;
                        end
                    end
                    FULL: begin
                        if (load) begin
                            state_next = FULL;
                            data_next  = in_data;
                        end else if (drain) begin
                            state_next = EMPTY;
                        end
                    end
                    default: state_next = EMPTY;
                endcase
                if (load) begin
                    cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg <= EMPTY;
                    data_reg  <= '0;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    data_reg  <= data_next;
                    cnt_reg   <= cnt_next;
                end
            end

            assign valid_arr[gi] = (state_reg == FULL);
            assign data_arr[gi]  = data_reg;
            assign cnt_arr[gi]   = cnt_reg;
        end
    endgenerate

    assign out0_valid = valid_arr[0];
    assign out0_data  = data_arr[0];
    assign cnt0       = cnt_arr[0];
    assign out1_valid = valid_arr[1];
    assign out1_data  = data_arr[1];
    assign cnt1       = cnt_arr[1];

endmodule
